// File: rtl/keyb_pkg.sv
// Shared definitions for the PS/2 keyboard controller: frame FSM state
// encoding, frame geometry constants and a parity helper.
package keyb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } keyb_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        KEYB_IDLE_LEVEL = 1'b1;

  // PS/2 uses odd parity: the 8 data bits plus the parity bit hold an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/keyb_fifo.sv
// Scancode FIFO with first-word fall-through head and sticky overflow flag.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write strobe and byte; dropped (overflow set) when full
//                   unless a pop happens in the same cycle
//   pop_i           read strobe; ignored while empty
//   ovf_clr_i       clears the overflow flag (a coincident new overflow wins)
//   head_o          oldest entry, 0 while empty
//   empty_o, full_o occupancy flags
//   overflow_o      sticky overflow flag
module keyb_fifo
  import keyb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q;
  logic             do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(FIFO_DEPTH));

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i & ~do_push) ovf_q <= 1'b1;
      else if (ovf_clr_i)    ovf_q <= 1'b0;
    end
  end

  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/keyb_ps2_ctrl.sv
// PS/2 keyboard receiver driving the CPU's IRQ_KEYB line.
// Synchronizes and glitch-filters the PS/2 clock, deframes device-to-host
// frames on filtered clock falling edges and queues scancodes in keyb_fifo.
// Ports:
//   CLOCK, RESET_N     system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DAT   raw asynchronous PS/2 lines
//   RD                 one-cycle pop strobe
//   O_DATA, O_READY    FIFO head (0 when empty) and non-empty flag
//   O_OVERFLOW/OVF_CLR sticky dropped-frame flag and its clear
//   IRQ_KEYB           level interrupt, high while bytes are pending
// Build option: define KEYB_PARITY_CHECK_EN to reject frames with bad odd
// parity; otherwise the parity bit is ignored.
module keyb_ps2_ctrl
  import keyb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 2500
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       RD,
  output logic [7:0] O_DATA,
  output logic       O_READY,
  output logic       O_OVERFLOW,
  input  logic       OVF_CLR,
  output logic       IRQ_KEYB
);

  localparam int unsigned FiltW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fall_event, dat_s;

  // Input conditioning: 2-FF synchronizers, then a run-length filter on the clock.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_q <= {2{KEYB_IDLE_LEVEL}};
      dat_sync_q <= {2{KEYB_IDLE_LEVEL}};
      filt_q     <= KEYB_IDLE_LEVEL;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltLast) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  // High in the cycle whose edge moves the filtered clock from 1 to 0.
  assign fall_event = filt_q & ~clk_sync_q[1] & (filt_cnt_q == FiltLast);
  assign dat_s      = dat_sync_q[1];

  keyb_state_e     state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            push_q, push_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout, frame_ok;

  assign timeout = (to_cnt_q == ToW'(TIMEOUT));

`ifdef KEYB_PARITY_CHECK_EN
  assign frame_ok = odd_parity_ok(shift_q, par_q);
`else
  logic unused_par;
  assign unused_par = par_q;
  assign frame_ok   = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    to_cnt_d  = fall_event ? '0 : (timeout ? to_cnt_q : to_cnt_q + ToW'(1));
    if (timeout && state_q != StIdle) begin
      state_d = StIdle;
    end else if (fall_event) begin
      case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s;
          state_d = StStop;
        end
        StStop: begin
          push_d  = dat_s & frame_ok;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      push_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      push_q    <= push_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  logic fifo_empty, unused_full;

  // shift_q is stable for the push cycle: it only moves on DATA-state falls.
  keyb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .clk_i     (CLOCK),
    .rst_ni    (RESET_N),
    .push_i    (push_q),
    .data_i    (shift_q),
    .pop_i     (RD),
    .ovf_clr_i (OVF_CLR),
    .head_o    (O_DATA),
    .empty_o   (fifo_empty),
    .full_o    (unused_full),
    .overflow_o(O_OVERFLOW)
  );

  assign O_READY  = ~fifo_empty;
  assign IRQ_KEYB = O_READY;

endmodule

// File: tb/tb_keyb_ps2_ctrl.sv
module tb_keyb_ps2_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 2500;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       RD = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [7:0] O_DATA;
  logic       O_READY, O_OVERFLOW, IRQ_KEYB;

  keyb_ps2_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .FILTER_LEN(4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .RD        (RD),
    .O_DATA    (O_DATA),
    .O_READY   (O_READY),
    .O_OVERFLOW(O_OVERFLOW),
    .OVF_CLR   (OVF_CLR),
    .IRQ_KEYB  (IRQ_KEYB)
  );

  always #20 CLOCK = ~CLOCK;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         ovf_exp = 1'b0;
  bit         pop_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides from the frame fields alone whether the byte is queued.
  function automatic bit frame_valid(input logic [7:0] data, input logic par, input logic stop);
    bit ok;
    ok = (stop == 1'b1);
`ifdef KEYB_PARITY_CHECK_EN
    ok = ok && (($countones({data, par}) % 2) == 1);
`endif
    return ok;
  endfunction

  function automatic void model_frame(input logic [7:0] data, input logic par,
                                      input logic stop, input bit rd_on_push);
    if (frame_valid(data, par, stop)) begin
      if (exp_q.size() >= DEPTH && !rd_on_push) ovf_exp = 1'b1;
      else exp_q.push_back(data);
    end
  endfunction

  // Device-to-host frame; nbits < 11 leaves a partial frame on the wire.
  // rd_on_push pulses RD exactly on the FIFO push cycle (6 edges after the
  // stop-bit fall: 2 sync + 4 filter samples, then the registered push).
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int nbits, input bit rd_on_push);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      repeat (10) @(posedge CLOCK);
      #1 PS2_CLK = 1'b0;
      if (i == 10) begin
        model_frame(data, par, stop, rd_on_push);
        if (rd_on_push) begin
          repeat (6) @(posedge CLOCK);
          #1;
          check("rdpush_ready", O_READY, 1'b1);
          check("rdpush_head", O_DATA, exp_q[0]);
          void'(exp_q.pop_front());
          RD = 1'b1;
          @(posedge CLOCK);
          #1 RD = 1'b0;
          repeat (13) @(posedge CLOCK);
        end else begin
          repeat (20) @(posedge CLOCK);
        end
      end else begin
        repeat (20) @(posedge CLOCK);
      end
      #1 PS2_CLK = 1'b1;
    end
    repeat (10) @(posedge CLOCK);
    #1 PS2_DAT = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] data);
    send_frame(data, ~^data, 1'b1, 11, 1'b0);
  endtask

  task automatic drain(input string name);
    pop_en = 1'b1;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge CLOCK);
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (5) @(posedge CLOCK);
    @(negedge CLOCK);
    check({name, "_ready"}, O_READY, 1'b0);
    check({name, "_irq"}, IRQ_KEYB, 1'b0);
    check({name, "_data"}, O_DATA, 8'h00);
    check({name, "_ovf"}, O_OVERFLOW, ovf_exp);
  endtask

  // Monitor: pops whenever the DUT presents data and compares against the queue.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (pop_en && O_READY && ($urandom_range(0, 2) == 0)) begin
        check("irq_level", IRQ_KEYB, 1'b1);
        if (exp_q.size() == 0) begin
          check("pop_unexpected", O_DATA, 8'h00);
          check("pop_unexpected_ready", O_READY, 1'b0);
        end else begin
          check("pop_data", O_DATA, exp_q.pop_front());
        end
        RD = 1'b1;
        @(negedge CLOCK);
        RD = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLOCK);
    check("rst_data", O_DATA, 8'h00);
    check("rst_ready", O_READY, 1'b0);
    check("rst_ovf", O_OVERFLOW, 1'b0);
    check("rst_irq", IRQ_KEYB, 1'b0);
    #1 RESET_N = 1'b1;
    repeat (5) @(posedge CLOCK);

    // Basic frame, then the same byte with wrong parity.
    pop_en = 1'b1;
    good_frame(8'h1C);
    drain("basic");
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    drain("badpar");

    // Nine frames with no reader: the ninth is dropped.
    pop_en = 1'b0;
    for (int i = 1; i <= 9; i++) good_frame(8'(i));
    @(negedge CLOCK);
    check("ovf_set", O_OVERFLOW, 1'b1);
    check("ovf_ready", O_READY, 1'b1);
    drain("ovf");
    @(posedge CLOCK);
    #1 OVF_CLR = 1'b1;
    @(posedge CLOCK);
    #1 OVF_CLR = 1'b0;
    ovf_exp = 1'b0;
    @(negedge CLOCK);
    check("ovf_clr", O_OVERFLOW, 1'b0);

    // Partial frame abandoned by timeout.
    send_frame(8'hA7, 1'b0, 1'b1, 5, 1'b0);
    repeat (TIMEOUT + 10) @(posedge CLOCK);
    good_frame(8'h5A);
    drain("timeout");

    // Short low glitch on PS2_CLK with data low must not start a frame.
    #1 PS2_DAT = 1'b0;
    @(posedge CLOCK);
    #1 PS2_CLK = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1 PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (20) @(posedge CLOCK);
    good_frame(8'h2B);
    drain("glitch");

    // Full FIFO with RD on the push cycle: both happen, no overflow.
    pop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) good_frame(8'($urandom));
    send_frame(8'hF0, ~^8'hF0, 1'b1, 11, 1'b1);
    @(negedge CLOCK);
    check("full_rd_ovf", O_OVERFLOW, 1'b0);
    check("full_rd_ready", O_READY, 1'b1);
    drain("full_rd");

    // Random frames: random data, parity and occasional bad stop bits.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, 1'($urandom), ($urandom_range(0, 5) != 0), 11, 1'b0);
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
